// File: rtl/dff_demux_pkg.sv
// Shared defaults and select encodings for the 1-to-2 registered demux.
// The target-select helper is used by the top to pick a destination slot.
package dff_demux_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    // Alternating mode overrides the explicit select with the round-robin pointer.
    function automatic logic sel_target(input logic alt_en, input logic alt_ptr, input logic in_sel);
        return alt_en ? alt_ptr : in_sel;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register with transfer counter; 1-cycle load-to-valid latency.
// Holds its word while downstream is not ready; a same-cycle drain and load keeps valid high.
module demux_slot
    import dff_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_drain_rdy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_drain,
    output logic [CNT_W-1:0] o_cnt
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_drain;

    assign w_drain = r_valid & i_drain_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_drain = w_drain;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/dff_demux_1to2.sv
// Registered 1-to-2 demux, 1-cycle latency; explicit or alternating destination.
// in_ready stalls only when the target slot is full and not draining this cycle.
module dff_demux_1to2
    import dff_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             alt_en,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             alt_ptr,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic r_alt_ptr;
    logic w_target;
    logic w_drain0;
    logic w_drain1;
    logic w_free0;
    logic w_free1;
    logic w_accept;
    logic w_load0;
    logic w_load1;

    assign w_target = sel_target(alt_en, r_alt_ptr, in_sel);

    // A slot draining this cycle can take the next word in the same cycle.
    assign w_free0  = ~out0_valid | w_drain0;
    assign w_free1  = ~out1_valid | w_drain1;
    assign in_ready = ~rst & ((w_target == SEL_OUT1) ? w_free1 : w_free0);

    assign w_accept = in_valid & in_ready;
    assign w_load0  = w_accept & (w_target == SEL_OUT0);
    assign w_load1  = w_accept & (w_target == SEL_OUT1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alt_ptr <= 1'b0;
        end else if (w_accept && alt_en) begin
            r_alt_ptr <= ~r_alt_ptr;
        end
    end

    assign alt_ptr = r_alt_ptr;

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load0),
        .i_data      (in_data),
        .i_drain_rdy (out0_ready),
        .o_valid     (out0_valid),
        .o_data      (out0_data),
        .o_drain     (w_drain0),
        .o_cnt       (cnt0)
    );

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load1),
        .i_data      (in_data),
        .i_drain_rdy (out1_ready),
        .o_valid     (out1_valid),
        .o_data      (out1_data),
        .o_drain     (w_drain1),
        .o_cnt       (cnt1)
    );

endmodule

// File: tb/tb_dff_demux_1to2.sv
// Bench for dff_demux_1to2: vector table, directed corner sequences, randomized run against a queue model.
module tb_dff_demux_1to2;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_sel;
    logic          alt_en;
    logic          out0_valid;
    logic          out0_ready;
    logic [W-1:0]  out0_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [W-1:0]  out1_data;
    logic          alt_ptr;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    int checks = 0;
    int errors = 0;

    dff_demux_1to2 #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .alt_en     (alt_en),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .alt_ptr    (alt_ptr),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [W-1:0]  id;
        logic          sel;
        logic          alt;
        logic          r0;
        logic          r1;
        logic          e_rdy;
        logic          e0v;
        logic [W-1:0]  e0d;
        logic          e1v;
        logic [W-1:0]  e1d;
        logic          eptr;
        logic [CW-1:0] ec0;
        logic [CW-1:0] ec1;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] id, input logic sel,
                         input logic alt, input logic r0, input logic r1);
        in_valid   = iv;
        in_data    = id;
        in_sel     = sel;
        alt_en     = alt;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Reference model: each output is a queue of capacity one.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic         m_ptr;
    int           m_c0;
    int           m_c1;

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset_in_ready", 32'(in_ready), 0);
        do_reset();
        chk("reset_out0_valid", 32'(out0_valid), 0);
        chk("reset_out1_valid", 32'(out1_valid), 0);
        chk("reset_out0_data", 32'(out0_data), 0);
        chk("reset_out1_data", 32'(out1_data), 0);
        chk("reset_cnt0", 32'(cnt0), 0);
        chk("reset_cnt1", 32'(cnt1), 0);
        chk("reset_alt_ptr", 32'(alt_ptr), 0);

        // Alternating mode, four back-to-back words, both readies high.
        vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 4'd0, 4'd0};
        vecs[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 4'd1, 4'd0};
        vecs[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 8'h00, 1'b1, 4'd1, 4'd1};
        vecs[3] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 4'd2, 4'd1};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'd2, 4'd2};
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].sel, vecs[i].alt, vecs[i].r0, vecs[i].r1);
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            tick();
            chk($sformatf("vec%0d_out0_valid", i), 32'(out0_valid), 32'(vecs[i].e0v));
            if (vecs[i].e0v) chk($sformatf("vec%0d_out0_data", i), 32'(out0_data), 32'(vecs[i].e0d));
            chk($sformatf("vec%0d_out1_valid", i), 32'(out1_valid), 32'(vecs[i].e1v));
            if (vecs[i].e1v) chk($sformatf("vec%0d_out1_data", i), 32'(out1_data), 32'(vecs[i].e1d));
            chk($sformatf("vec%0d_alt_ptr", i), 32'(alt_ptr), 32'(vecs[i].eptr));
            chk($sformatf("vec%0d_cnt0", i), 32'(cnt0), 32'(vecs[i].ec0));
            chk($sformatf("vec%0d_cnt1", i), 32'(cnt1), 32'(vecs[i].ec1));
        end

        // Asynchronous reset while out0 holds 0xA5 and alt_ptr is 1.
        drive(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_out0_data", 32'(out0_data), 32'h A5);
        chk("pre_rst_alt_ptr", 32'(alt_ptr), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out0_valid", 32'(out0_valid), 0);
        chk("mid_rst_out0_data", 32'(out0_data), 0);
        chk("mid_rst_cnt0", 32'(cnt0), 0);
        chk("mid_rst_cnt1", 32'(cnt1), 0);
        chk("mid_rst_alt_ptr", 32'(alt_ptr), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_out0_valid", 32'(out0_valid), 0);
        chk("post_rst_out1_valid", 32'(out1_valid), 0);

        // Fixed select to out1.
        drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("fixed_out1_valid", 32'(out1_valid), 1);
        chk("fixed_out1_data", 32'(out1_data), 32'h3C);
        chk("fixed_out0_valid", 32'(out0_valid), 0);
        tick();
        chk("fixed_cnt1", 32'(cnt1), 1);
        chk("fixed_out1_cleared", 32'(out1_valid), 0);
        chk("fixed_alt_ptr_hold", 32'(alt_ptr), 0);

        // Backpressure on out0, with out1 still usable.
        drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("bp_in_ready", 32'(in_ready), 0);
        tick();
        chk("bp_out0_hold_data", 32'(out0_data), 32'h11);
        chk("bp_out0_hold_valid", 32'(out0_valid), 1);
        drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("indep_in_ready", 32'(in_ready), 1);
        tick();
        chk("indep_out1_data", 32'(out1_data), 32'h77);
        chk("indep_out1_valid", 32'(out1_valid), 1);
        chk("indep_out0_data", 32'(out0_data), 32'h11);
        chk("indep_out0_valid", 32'(out0_valid), 1);
        drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("bp_release_out0_data", 32'(out0_data), 32'h22);
        chk("bp_release_out0_valid", 32'(out0_valid), 1);
        tick();
        chk("bp_cnt0", 32'(cnt0), 2);
        chk("bp_cnt1", 32'(cnt1), 2);

        // Counter wrap: 17 drains on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("wrap_cnt0", 32'(cnt0), 1);

        // Randomized run against the queue model.
        do_reset();
        q0.delete();
        q1.delete();
        m_ptr = 1'b0;
        m_c0  = 0;
        m_c1  = 0;
        alt_en = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic m_tgt;
            logic m_rdy;
            logic d0;
            logic d1;
            logic acc;
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = 8'($urandom);
            in_sel     = 1'($urandom);
            if ($urandom_range(0, 15) == 0) alt_en = ~alt_en;
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 2) != 0);
            #1;
            m_tgt = alt_en ? m_ptr : in_sel;
            d0 = (q0.size() != 0) && out0_ready;
            d1 = (q1.size() != 0) && out1_ready;
            m_rdy = m_tgt ? ((q1.size() == 0) || d1) : ((q0.size() == 0) || d0);
            chk("rand_in_ready", 32'(in_ready), 32'(m_rdy));
            acc = in_valid && m_rdy;
            if (d0) begin void'(q0.pop_front()); m_c0++; end
            if (d1) begin void'(q1.pop_front()); m_c1++; end
            if (acc) begin
                if (m_tgt) q1.push_back(in_data);
                else       q0.push_back(in_data);
                if (alt_en) m_ptr = ~m_ptr;
            end
            tick();
            chk("rand_out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
            chk("rand_out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
            if (q0.size() != 0) chk("rand_out0_data", 32'(out0_data), 32'(q0[0]));
            if (q1.size() != 0) chk("rand_out1_data", 32'(out1_data), 32'(q1[0]));
            chk("rand_alt_ptr", 32'(alt_ptr), 32'(m_ptr));
            chk("rand_cnt0", 32'(cnt0), 32'(m_c0 % 16));
            chk("rand_cnt1", 32'(cnt1), 32'(m_c1 % 16));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_demux_1to2.md
DFF_DEMUX_1TO2 -- requirements
Module: dff_demux_1to2

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of each per-output transfer counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream word.
REQ-008 SHALL have port in_sel  input  1  destination select, 0 = out0, 1 = out1; used when alt_en=0.
REQ-009 SHALL have port alt_en  input  1  1 = ignore in_sel and alternate destinations.
REQ-010 SHALL have ports out0_valid/out1_valid  output  1  slot holds a word.
REQ-011 SHALL have ports out0_ready/out1_ready  input  1  downstream consumes word.
REQ-012 SHALL have ports out0_data/out1_data  output  WIDTH  slot word.
REQ-013 SHALL have port alt_ptr  output  1  next destination in alternating mode.
REQ-014 SHALL have ports cnt0/cnt1  output  CNT_W  words delivered on out0/out1.

Function
REQ-015 SHALL define target = alt_en ? alt_ptr : in_sel, evaluated combinationally each cycle.
REQ-016 SHALL hold one one-entry register slot per output.
REQ-017 SHALL drive in_ready = 1 when the target slot is empty, or full and drained this cycle (outN_valid && outN_ready); otherwise 0.
REQ-018 SHALL drive in_ready from the slot state, alt_en, in_sel, alt_ptr and outN_ready only, never from in_valid.
REQ-019 SHALL accept a word when in_valid && in_ready; the word SHALL appear on the target outN_data with outN_valid=1 on the next cycle (latency 1).
REQ-020 SHALL never write an accepted word into the non-target slot; the non-target slot's contents and valid SHALL be unaffected.
REQ-021 SHALL keep outN_data and outN_valid stable while outN_valid && !outN_ready.
REQ-022 SHALL clear outN_valid on the cycle after a drain, unless the same slot is refilled in that cycle.
REQ-023 SHALL, on a simultaneous drain and fill of the same slot, keep outN_valid at 1 and load the new word (full throughput, 1 word/cycle per output).
REQ-024 SHALL allow both outputs to drain in the same cycle, independently.
REQ-025 SHALL toggle alt_ptr on every accepted word while alt_en=1, and hold it while alt_en=0 or when no word is accepted.
REQ-026 SHALL apply alt_en changes from the next evaluation of the target; toggling alt_en SHALL NOT reset alt_ptr.
REQ-027 SHALL increment cntN by 1 on each drain of outN (outN_valid && outN_ready), wrapping from 2^CNT_W-1 to 0.
REQ-028 SHALL, when in_valid=1 and the target slot is full and not draining, stall (in_ready=0) without dropping or reordering words.
REQ-029 SHALL preserve order per output: words reach outN in acceptance order.

Reset
REQ-030 SHALL, on rst=1 and asynchronously, force out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, alt_ptr=0, cnt0=0 and cnt1=0.
REQ-031 SHALL drive in_ready=0 while rst=1.
REQ-032 SHALL discard any held word when reset is asserted mid-operation; no word SHALL be presented after reset release until a new acceptance.

Structure
REQ-033 SHALL take the WIDTH and CNT_W defaults from the shared package dff_demux_pkg, which also holds the select encodings (SEL_OUT0=0, SEL_OUT1=1).
REQ-034 SHALL implement each output as one instance of the sub-module demux_slot: a one-entry register with load, drain, valid, data and counter.
REQ-035 SHALL instantiate demux_slot twice; the top level SHALL hold only the target/ptr logic and the in_ready mux.

Verification
REQ-036 SHALL cover reset: assert rst mid-transfer with out0 holding 0xA5 -> the same cycle, out0_valid=0, out0_data=0, cnt0=0 and alt_ptr=0.
REQ-037 SHALL cover fixed select: alt_en=0, in_sel=1, in_data=0x3C, out1_ready=1 -> the next cycle, out1_valid=1 and out1_data=0x3C; out0_valid stays 0; cnt1=1 the cycle after.
REQ-038 SHALL cover alternating mode: alt_en=1, send 0x01,0x02,0x03,0x04 back-to-back with both readies=1 -> out0 gets 0x01,0x03, out1 gets 0x02,0x04, and alt_ptr ends at 0.
REQ-039 SHALL cover backpressure: in_sel=0, out0_ready=0, send 0x11 then 0x22 -> in_ready=0 on the second word, out0_data holds 0x11; raise out0_ready -> 0x22 appears the next cycle with no loss.
REQ-040 SHALL cover independent outputs: out0 full and stalled, in_sel=1, send 0x77 -> in_ready=1 and out1 receives 0x77 while out0 is unchanged.
REQ-041 SHALL cover counter wrap: with CNT_W=4, drain 17 words on out0 -> cnt0 reads 1.
